count_hex_display: RTL and testbench

- Downstream consumer of the 8-bit counter value.
- Takes values through a valid/ready handshake and renders them as two hex digits on a time-multiplexed common-cathode 7-segment pair.
- Includes a scan prescaler and inter-digit blanking (anti-ghosting).
- New values take effect only at frame boundaries, so a frame never shows one old digit and one new digit.
- Outputs map to uo_out[6:0] (segments) and uio_out[1:0] (digit enables) at top level.

---
 rtl/count_hex_display_pkg.sv | 37 +++
 rtl/count_hex_display_hex_to_seg7.sv | 34 +++
 rtl/count_hex_display.sv | 162 ++++++++++++++++
 tb/tb_count_hex_display.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_hex_display_pkg.sv
// count_hex_display_pkg
//   Shared definitions for the two-digit hex display driver:
//   - scan FSM state encoding (ST_BLANK0 / ST_DIG0 / ST_BLANK1 / ST_DIG1)
//   - 7-segment patterns for hex digits 0..F (active high, bit0=a .. bit6=g)
//   - one-hot digit enable codes (DIG_NONE / DIG_LO / DIG_HI)
package count_hex_display_pkg;

    typedef enum logic [1:0] {
        ST_BLANK0 = 2'd0,
        ST_DIG0   = 2'd1,
        ST_BLANK1 = 2'd2,
        ST_DIG1   = 2'd3
    } state_t;

    localparam logic [6:0] SEG_OFF   = 7'h00;
    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;

    localparam logic [1:0] DIG_NONE = 2'b00;
    localparam logic [1:0] DIG_LO   = 2'b01;
    localparam logic [1:0] DIG_HI   = 2'b10;

endpackage

// File: rtl/count_hex_display_hex_to_seg7.sv
// hex_to_seg7
//   Purely combinational hex nibble to 7-segment decoder.
//   Ports:
//     nibble_i  [3:0]  hex digit to render
//     seg_o     [6:0]  segment pattern, active high, bit0=a .. bit6=g
module hex_to_seg7
    import count_hex_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (nibble_i)
            4'h0:    seg_o = SEG_HEX_0;
            4'h1:    seg_o = SEG_HEX_1;
            4'h2:    seg_o = SEG_HEX_2;
            4'h3:    seg_o = SEG_HEX_3;
            4'h4:    seg_o = SEG_HEX_4;
            4'h5:    seg_o = SEG_HEX_5;
            4'h6:    seg_o = SEG_HEX_6;
            4'h7:    seg_o = SEG_HEX_7;
            4'h8:    seg_o = SEG_HEX_8;
            4'h9:    seg_o = SEG_HEX_9;
            4'hA:    seg_o = SEG_HEX_A;
            4'hB:    seg_o = SEG_HEX_B;
            4'hC:    seg_o = SEG_HEX_C;
            4'hD:    seg_o = SEG_HEX_D;
            4'hE:    seg_o = SEG_HEX_E;
            default: seg_o = SEG_HEX_F;
        endcase
    end

endmodule

// File: rtl/count_hex_display.sv
// count_hex_display
//   Accepts 8-bit values over a valid/ready handshake and shows them as two
//   hex digits on a time-multiplexed common-cathode 7-segment pair. Scan order
//   is BLANK0 -> DIG0 -> BLANK1 -> DIG1; blank slots keep both digits dark to
//   avoid ghosting. A new value is swapped in only on the last cycle of DIG1,
//   so a frame never mixes digits of two values.
//   Optional feature: define COUNT_HEX_DISPLAY_LZB_EN for leading-zero
//   blanking (DIG1 stays dark when the high nibble is zero).
//   Parameters:
//     PRESCALE_W    digit slot length is 2^PRESCALE_W cycles
//     BLANK_CYCLES  dark cycles before each digit slot, 0 removes the blank slots
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     ena            scan enable; low freezes the scan and darkens the display
//     value_i        value to display, with value_valid_i / value_ready_o
//     seg_o  [6:0]   segments, active high, bit0=a .. bit6=g
//     dig_o  [1:0]   digit enables, bit0 = low nibble, bit1 = high nibble
module count_hex_display
    import count_hex_display_pkg::*;
#(
    parameter int PRESCALE_W   = 10,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] value_i,
    input  logic       value_valid_i,
    output logic       value_ready_o,
    output logic [6:0] seg_o,
    output logic [1:0] dig_o
);

    localparam int CW = (PRESCALE_W > 8) ? PRESCALE_W : 8;
    localparam logic [CW-1:0] DIG_LAST   = CW'((2 ** PRESCALE_W) - 1);
    localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
    localparam bit            NO_BLANK   = (BLANK_CYCLES == 0);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    disp_q, disp_d;
    logic [7:0]    pend_q;
    logic          pend_vld_q;
    logic          boundary;
    logic          swap;
    logic [3:0]    nibble;
    logic [6:0]    dec_seg;
    logic [6:0]    seg_d;
    logic [1:0]    dig_d;

    // ---------------- scan FSM: state register ----------------
    // NOTE: every flop in this design is written with <= so that all of them
    // sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- scan FSM: next state ----------------
    // NOTE: defaults first, so every path through the block assigns every
    // output and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (ena) begin
            cnt_d = cnt_q + 1'b1;
            case (state_q)
                ST_BLANK0: if (NO_BLANK || cnt_q == BLANK_LAST) begin
                    state_d = ST_DIG0;
                    cnt_d   = '0;
                end
                ST_DIG0: if (cnt_q == DIG_LAST) begin
                    state_d = NO_BLANK ? ST_DIG1 : ST_BLANK1;
                    cnt_d   = '0;
                end
                ST_BLANK1: if (NO_BLANK || cnt_q == BLANK_LAST) begin
                    state_d = ST_DIG1;
                    cnt_d   = '0;
                end
                default: if (cnt_q == DIG_LAST) begin
                    state_d = NO_BLANK ? ST_DIG0 : ST_BLANK0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // ---------------- handshake and display register ----------------
    assign boundary      = ena && (state_q == ST_DIG1) && (cnt_q == DIG_LAST);
    assign swap          = boundary && pend_vld_q;
    assign value_ready_o = ~pend_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q     <= 8'h00;
            pend_q     <= 8'h00;
            pend_vld_q <= 1'b0;
        end else if (swap) begin
            disp_q     <= pend_q;
            pend_vld_q <= 1'b0;
        end else if (value_valid_i && !pend_vld_q) begin
            pend_q     <= value_i;
            pend_vld_q <= 1'b1;
        end
    end

    // The outputs are registered from the next state, so the digit shown in
    // the first cycle after a boundary must already use the swapped value.
    assign disp_d = swap ? pend_q : disp_q;

    // ---------------- scan FSM: outputs ----------------
    assign nibble = (state_d == ST_DIG1) ? disp_d[7:4] : disp_d[3:0];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (nibble),
        .seg_o    (dec_seg)
    );

    always_comb begin
        seg_d = SEG_OFF;
        dig_d = DIG_NONE;
        if (ena) begin
            case (state_d)
                ST_DIG0: begin
                    seg_d = dec_seg;
                    dig_d = DIG_LO;
                end
                ST_DIG1: begin
`ifdef COUNT_HEX_DISPLAY_LZB_EN
                    if (disp_d[7:4] != 4'h0) begin
                        seg_d = dec_seg;
                        dig_d = DIG_HI;
                    end
`else
                    seg_d = dec_seg;
                    dig_d = DIG_HI;
`endif
                end
                default: begin
                    seg_d = SEG_OFF;
                    dig_d = DIG_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_o <= SEG_OFF;
            dig_o <= DIG_NONE;
        end else begin
            seg_o <= seg_d;
            dig_o <= dig_d;
        end
    end

endmodule

// File: tb/tb_count_hex_display.sv
// tb_count_hex_display
//   Directed bench for count_hex_display. dut1 runs PRESCALE_W=3,
//   BLANK_CYCLES=2 (20-cycle frame); dut2 runs PRESCALE_W=3, BLANK_CYCLES=0
//   (16-cycle frame). A small reference model follows each DUT every cycle;
//   directed steps add hand-computed spot checks on top.
module tb_count_hex_display;

`ifdef COUNT_HEX_DISPLAY_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       ena, ena2;
    logic [7:0] value, value2;
    logic       valid, valid2;
    logic       ready, ready2;
    logic [6:0] seg, seg2;
    logic [1:0] dig, dig2;

    int checks = 0;
    int fails  = 0;

    // reference model state, dut1
    int         p;
    logic [7:0] m_disp, m_pend;
    logic       m_pv;
    // reference model state, dut2
    bit         q_init;
    int         c2;
    logic [7:0] m2_disp, m2_pend;
    logic       m2_pv;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    count_hex_display #(.PRESCALE_W(3), .BLANK_CYCLES(2)) dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .value_i       (value),
        .value_valid_i (valid),
        .value_ready_o (ready),
        .seg_o         (seg),
        .dig_o         (dig)
    );

    count_hex_display #(.PRESCALE_W(3), .BLANK_CYCLES(0)) dut2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena2),
        .value_i       (value2),
        .value_valid_i (valid2),
        .value_ready_o (ready2),
        .seg_o         (seg2),
        .dig_o         (dig2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        p       = 0;
        m_disp  = 8'h00;
        m_pend  = 8'h00;
        m_pv    = 1'b0;
        q_init  = 1'b1;
        c2      = 0;
        m2_disp = 8'h00;
        m2_pend = 8'h00;
        m2_pv   = 1'b0;
    endtask

    // One clock: advance both models with the inputs the DUTs saw on the
    // edge, then compare every output 1 time unit later.
    task automatic tick();
        logic       en;
        logic [1:0] e_dig, e_dig2;
        logic [6:0] e_seg, e_seg2;
        @(posedge clk);
        en = ena;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (en && p == 19 && m_pv) begin
                m_disp = m_pend;
                m_pv   = 1'b0;
            end else if (valid && !m_pv) begin
                m_pend = value;
                m_pv   = 1'b1;
            end
            if (en) p = (p + 1) % 20;

            if (!q_init && c2 == 15 && m2_pv) begin
                m2_disp = m2_pend;
                m2_pv   = 1'b0;
            end else if (valid2 && !m2_pv) begin
                m2_pend = value2;
                m2_pv   = 1'b1;
            end
            if (q_init) begin
                q_init = 1'b0;
                c2     = 0;
            end else begin
                c2 = (c2 + 1) % 16;
            end
        end
        #1;
        e_dig = 2'b00;
        e_seg = 7'h00;
        if (rst_n && en && p >= 2 && p < 10) begin
            e_dig = 2'b01;
            e_seg = hex_tab[m_disp[3:0]];
        end else if (rst_n && en && p >= 12 && !(LZB && m_disp[7:4] == 4'h0)) begin
            e_dig = 2'b10;
            e_seg = hex_tab[m_disp[7:4]];
        end
        check("dut1_dig", {6'b0, dig}, {6'b0, e_dig});
        check("dut1_seg", {1'b0, seg}, {1'b0, e_seg});
        check("dut1_ready", {7'b0, ready}, {7'b0, !m_pv});

        e_dig2 = 2'b00;
        e_seg2 = 7'h00;
        if (!q_init && c2 < 8) begin
            e_dig2 = 2'b01;
            e_seg2 = hex_tab[m2_disp[3:0]];
        end else if (!q_init && !(LZB && m2_disp[7:4] == 4'h0)) begin
            e_dig2 = 2'b10;
            e_seg2 = hex_tab[m2_disp[7:4]];
        end
        check("dut2_dig", {6'b0, dig2}, {6'b0, e_dig2});
        check("dut2_seg", {1'b0, seg2}, {1'b0, e_seg2});
        check("dut2_ready", {7'b0, ready2}, {7'b0, !m2_pv});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_phase(input int target);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (p == target) hit = 1'b1;
            else tick();
        end
        if (!hit) begin
            fails++;
            $error("FAIL wait_phase observed=%0d expected=%0d", p, target);
        end
    endtask

    task automatic wait_c2(input int target);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (!q_init && c2 == target) hit = 1'b1;
            else tick();
        end
        if (!hit) begin
            fails++;
            $error("FAIL wait_c2 observed=%0d expected=%0d", c2, target);
        end
    endtask

    initial begin
        ena    = 1'b1;
        ena2   = 1'b1;
        valid  = 1'b0;
        valid2 = 1'b0;
        value  = 8'h00;
        value2 = 8'h00;
        model_reset();

        // reset state, applied between edges
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_seg", {1'b0, seg}, 8'h00);
        check("rst_dig", {6'b0, dig}, 8'h00);
        check("rst_ready", {7'b0, ready}, 8'h01);
        ticks(2);
        #3 rst_n = 1'b1;

        // 1: idle frame shows 00
        ticks(1);
        check("t1_blank0_dig", {6'b0, dig}, 8'h00);
        tick();
        check("t1_dig0_dig", {6'b0, dig}, 8'h01);
        check("t1_dig0_seg", {1'b0, seg}, 8'h3F);
        ticks(30);

        // 2: A7 accepted mid-DIG0, shown from the next frame
        wait_phase(5);
        value = 8'hA7;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        check("t2_ready_low", {7'b0, ready}, 8'h00);
        wait_phase(12);
        if (!LZB) check("t2_old_dig1", {1'b0, seg}, 8'h3F);
        wait_phase(0);
        check("t2_ready_back", {7'b0, ready}, 8'h01);
        wait_phase(2);
        check("t2_new_dig0", {1'b0, seg}, 8'h07);
        wait_phase(12);
        check("t2_new_dig1", {1'b0, seg}, 8'h77);
        check("t2_new_dig1_en", {6'b0, dig}, 8'h02);

        // 3: back-to-back 12 / 34 with valid held high
        wait_phase(4);
        value = 8'h12;
        valid = 1'b1;
        tick();
        value = 8'h34;
        tick();
        check("t3_second_blocked", {7'b0, ready}, 8'h00);
        wait_phase(1);
        valid = 1'b0;
        check("t3_34_taken", {7'b0, ready}, 8'h00);
        wait_phase(3);
        check("t3_12_dig0", {1'b0, seg}, 8'h5B);
        wait_phase(13);
        check("t3_12_dig1", {1'b0, seg}, 8'h06);
        wait_phase(3);
        check("t3_34_dig0", {1'b0, seg}, 8'h66);
        wait_phase(13);
        check("t3_34_dig1", {1'b0, seg}, 8'h4F);

        // 4: ena low for 5 cycles inside DIG1
        wait_phase(14);
        ena = 1'b0;
        ticks(5);
        check("t4_gap_dig", {6'b0, dig}, 8'h00);
        check("t4_gap_seg", {1'b0, seg}, 8'h00);
        ena = 1'b1;
        tick();
        check("t4_resume_dig", {6'b0, dig}, 8'h02);
        ticks(25);

        // 5: async reset mid-DIG1 with a value pending
        wait_phase(12);
        value = 8'h9C;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        check("t5_pending", {7'b0, ready}, 8'h00);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_async_seg", {1'b0, seg}, 8'h00);
        check("t5_async_dig", {6'b0, dig}, 8'h00);
        check("t5_async_ready", {7'b0, ready}, 8'h01);
        #1 rst_n = 1'b1;
        wait_phase(3);
        check("t5_after_dig0", {1'b0, seg}, 8'h3F);
        ticks(20);

        // 6: BLANK_CYCLES=0 instance showing 05
        value2 = 8'h05;
        valid2 = 1'b1;
        tick();
        valid2 = 1'b0;
        ticks(20);
        wait_c2(3);
        check("t6_dig0_en", {6'b0, dig2}, 8'h01);
        check("t6_dig0_seg", {1'b0, seg2}, 8'h6D);
        wait_c2(10);
        check("t6_dig1_en", {6'b0, dig2}, LZB ? 8'h00 : 8'h02);
        check("t6_dig1_seg", {1'b0, seg2}, LZB ? 8'h00 : 8'h3F);
        ticks(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
